// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file write port between the writeback
// pipeline (requester 0) and a long-latency unit (requester 1), with a pending-write mask.
`timescale 1ns/1ps

module regfile_wb_arbiter #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req0_valid,
    output logic                     req0_ready,
    input  logic [$clog2(NREG)-1:0]  req0_rd,
    input  logic [XLEN-1:0]          req0_data,
    input  logic                     req1_valid,
    output logic                     req1_ready,
    input  logic [$clog2(NREG)-1:0]  req1_rd,
    input  logic [XLEN-1:0]          req1_data,
    output logic                     wb_we,
    output logic [$clog2(NREG)-1:0]  wb_rd,
    output logic [XLEN-1:0]          wb_data,
    output logic [NREG-1:0]          pend_mask
);

    localparam int RD_W = $clog2(NREG);

    logic [1:0]      valid_in;
    logic [RD_W-1:0] rd_in   [2];
    logic [XLEN-1:0] data_in [2];

    logic [1:0]      slot_full_p0;
    logic [RD_W-1:0] slot_rd_p0   [2];
    logic [XLEN-1:0] slot_data_p0 [2];
    logic            rr_last_p0;

    logic [1:0]      gnt;
    logic [1:0]      ready;
    logic [1:0]      accept;
    logic [1:0]      load;

    function automatic logic [NREG-1:0] rd_onehot(input logic [RD_W-1:0] rd);
        logic [NREG-1:0] m;
        m     = '0;
        m[rd] = 1'b1;
        return m;
    endfunction

    assign valid_in   = {req1_valid, req0_valid};
    assign rd_in[0]   = req0_rd;
    assign rd_in[1]   = req1_rd;
    assign data_in[0] = req0_data;
    assign data_in[1] = req1_data;

    // Grant depends only on slot state, so ready never depends on valid.
    always_comb begin
        gnt = 2'b00;
        case (slot_full_p0)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = rr_last_p0 ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    assign ready      = ~slot_full_p0 | gnt;
    assign accept     = valid_in & ready;
    assign req0_ready = ready[0];
    assign req1_ready = ready[1];

    always_comb begin
        load = 2'b00;
        for (int i = 0; i < 2; i++) begin
            load[i] = accept[i] && (rd_in[i] != '0);
        end
    end

    // Stage p0: holding slots and round-robin pointer (x0 writes are dropped here).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_full_p0 <= 2'b00;
            rr_last_p0   <= 1'b1;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (load[i]) begin
                    slot_full_p0[i] <= 1'b1;
                end else if (gnt[i]) begin
                    slot_full_p0[i] <= 1'b0;
                end
            end
            if (&slot_full_p0) begin
                rr_last_p0 <= gnt[1];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (load[i]) begin
                slot_rd_p0[i]   <= rd_in[i];
                slot_data_p0[i] <= data_in[i];
            end
        end
    end

    // Stage p1: registered write port into the register file.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_we   <= 1'b0;
            wb_rd   <= '0;
            wb_data <= '0;
        end else begin
            wb_we <= |gnt;
            if (gnt[0]) begin
                wb_rd   <= slot_rd_p0[0];
                wb_data <= slot_data_p0[0];
            end else if (gnt[1]) begin
                wb_rd   <= slot_rd_p0[1];
                wb_data <= slot_data_p0[1];
            end
        end
    end

    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < 2; i++) begin
            if (slot_full_p0[i]) begin
                pend_mask = pend_mask | rd_onehot(slot_rd_p0[i]);
            end
        end
        if (wb_we) begin
            pend_mask = pend_mask | rd_onehot(wb_rd);
        end
        pend_mask[0] = 1'b0;
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed testbench for regfile_wb_arbiter: one task per scenario, inline checks.
`timescale 1ns/1ps

module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [4:0]  req0_rd, req1_rd;
    logic [31:0] req0_data, req1_data;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [31:0] pend_mask;

    int vectors = 0;
    int miscompares = 0;

    regfile_wb_arbiter #(.XLEN(32), .NREG(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_rd(req0_rd), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_rd(req1_rd), .req1_data(req1_data),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .pend_mask(pend_mask)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        req0_valid = 1'b0; req0_rd = '0; req0_data = '0;
        req1_valid = 1'b0; req1_rd = '0; req1_data = '0;
    endtask

    task automatic do_reset;
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset;
        idle_inputs();
        rst_n = 1'b0;
        #2;
        vectors++;
        if (wb_we !== 1'b0 || wb_rd !== 5'd0 || wb_data !== 32'd0 || pend_mask !== 32'd0 ||
            req0_ready !== 1'b1 || req1_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_state: we=%b rd=%0d data=%h pend=%h rdy0=%b rdy1=%b, expected 0/0/0/0/1/1",
                     wb_we, wb_rd, wb_data, pend_mask, req0_ready, req1_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_single;
        do_reset();
        req0_valid = 1'b1; req0_rd = 5'd5; req0_data = 32'hAAAA0005;
        vectors++;
        if (req0_ready !== 1'b1) begin
            miscompares++; $display("FAIL single_ready: got %b expected 1", req0_ready);
        end
        tick();
        idle_inputs();
        vectors++;
        if (pend_mask !== 32'h20 || wb_we !== 1'b0) begin
            miscompares++; $display("FAIL single_pend: pend=%h we=%b expected 00000020/0", pend_mask, wb_we);
        end
        tick();
        vectors++;
        if (wb_we !== 1'b1 || wb_rd !== 5'd5 || wb_data !== 32'hAAAA0005 || pend_mask !== 32'h20) begin
            miscompares++;
            $display("FAIL single_wb: we=%b rd=%0d data=%h pend=%h expected 1/5/aaaa0005/00000020",
                     wb_we, wb_rd, wb_data, pend_mask);
        end
        tick();
        vectors++;
        if (wb_we !== 1'b0 || pend_mask !== 32'h0 || wb_rd !== 5'd5 || wb_data !== 32'hAAAA0005) begin
            miscompares++;
            $display("FAIL single_drop: we=%b pend=%h rd=%0d data=%h expected 0/0/5(held)/aaaa0005(held)",
                     wb_we, pend_mask, wb_rd, wb_data);
        end
    endtask

    task automatic test_contention;
        int i0, i1, j;
        logic e0, e1, a0, a1;
        logic [4:0] exp_rd;
        do_reset();
        i0 = 0; i1 = 0;
        for (int k = 0; k <= 17; k++) begin
            req0_valid = (i0 < 8); req0_rd = 5'(1 + i0);  req0_data = 32'hC000_0000 | 32'(1 + i0);
            req1_valid = (i1 < 8); req1_rd = 5'(17 + i1); req1_data = 32'hD000_0000 | 32'(17 + i1);
            e0 = (k == 0) || (k % 2 == 1);
            e1 = (k == 0) || (k % 2 == 0);
            if (k <= 15) begin
                vectors++;
                if (req0_ready !== e0 || req1_ready !== e1) begin
                    miscompares++;
                    $display("FAIL contention_ready k=%0d: rdy0=%b rdy1=%b expected %b/%b",
                             k, req0_ready, req1_ready, e0, e1);
                end
            end
            a0 = req0_valid && e0;
            a1 = req1_valid && e1;
            tick();
            if (a0) i0++;
            if (a1) i1++;
            if (k >= 1 && k <= 16) begin
                j = k - 1;
                exp_rd = (j % 2 == 0) ? 5'(1 + j / 2) : 5'(17 + j / 2);
                vectors++;
                if (wb_we !== 1'b1 || wb_rd !== exp_rd ||
                    wb_data !== (((j % 2 == 0) ? 32'hC000_0000 : 32'hD000_0000) | 32'(exp_rd))) begin
                    miscompares++;
                    $display("FAIL contention_wb edge=%0d: we=%b rd=%0d data=%h expected rd=%0d",
                             k, wb_we, wb_rd, wb_data, exp_rd);
                end
            end
            if (k == 17) begin
                vectors++;
                if (wb_we !== 1'b0 || pend_mask !== 32'h0) begin
                    miscompares++;
                    $display("FAIL contention_drain: we=%b pend=%h expected 0/0", wb_we, pend_mask);
                end
            end
        end
        idle_inputs();
    endtask

    task automatic test_back_to_back;
        do_reset();
        for (int k = 0; k <= 9; k++) begin
            if (k < 8) begin
                req1_valid = 1'b1; req1_rd = 5'(10 + k); req1_data = 32'h0B0B_0000 | 32'(k);
                vectors++;
                if (req1_ready !== 1'b1) begin
                    miscompares++; $display("FAIL b2b_ready k=%0d: got %b expected 1", k, req1_ready);
                end
            end else begin
                idle_inputs();
            end
            tick();
            if (k >= 1 && k <= 8) begin
                vectors++;
                if (wb_we !== 1'b1 || wb_rd !== 5'(9 + k) || wb_data !== (32'h0B0B_0000 | 32'(k - 1))) begin
                    miscompares++;
                    $display("FAIL b2b_wb edge=%0d: we=%b rd=%0d data=%h expected 1/%0d/%h",
                             k, wb_we, wb_rd, wb_data, 9 + k, 32'h0B0B_0000 | 32'(k - 1));
                end
            end
            if (k == 9) begin
                vectors++;
                if (wb_we !== 1'b0) begin
                    miscompares++; $display("FAIL b2b_end: we=%b expected 0", wb_we);
                end
            end
        end
    endtask

    task automatic test_rd_zero;
        do_reset();
        req0_valid = 1'b1; req0_rd = 5'd0; req0_data = 32'hDEAD0000;
        req1_valid = 1'b1; req1_rd = 5'd3; req1_data = 32'h33330003;
        vectors++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b1) begin
            miscompares++; $display("FAIL rd0_ready: rdy0=%b rdy1=%b expected 1/1", req0_ready, req1_ready);
        end
        tick();
        req1_valid = 1'b0;
        vectors++;
        if (pend_mask !== 32'h8 || req0_ready !== 1'b1) begin
            miscompares++; $display("FAIL rd0_pend: pend=%h rdy0=%b expected 00000008/1", pend_mask, req0_ready);
        end
        tick();
        req0_valid = 1'b0;
        vectors++;
        if (wb_we !== 1'b1 || wb_rd !== 5'd3 || wb_data !== 32'h33330003 || pend_mask !== 32'h8) begin
            miscompares++;
            $display("FAIL rd0_wb: we=%b rd=%0d data=%h pend=%h expected 1/3/33330003/00000008",
                     wb_we, wb_rd, wb_data, pend_mask);
        end
        tick();
        vectors++;
        if (wb_we !== 1'b0 || pend_mask !== 32'h0) begin
            miscompares++; $display("FAIL rd0_after: we=%b pend=%h expected 0/0 (x0 write must not appear)", wb_we, pend_mask);
        end
        tick();
        vectors++;
        if (wb_we !== 1'b0) begin
            miscompares++; $display("FAIL rd0_late: we=%b expected 0", wb_we);
        end
    endtask

    task automatic test_same_rd;
        do_reset();
        req0_valid = 1'b1; req0_rd = 5'd7; req0_data = 32'h11;
        req1_valid = 1'b1; req1_rd = 5'd7; req1_data = 32'h22;
        tick();
        idle_inputs();
        vectors++;
        if (pend_mask !== 32'h80 || req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL same_rd_held: pend=%h rdy0=%b rdy1=%b expected 00000080/1/0", pend_mask, req0_ready, req1_ready);
        end
        tick();
        vectors++;
        if (wb_we !== 1'b1 || wb_rd !== 5'd7 || wb_data !== 32'h11 || pend_mask !== 32'h80) begin
            miscompares++;
            $display("FAIL same_rd_first: we=%b rd=%0d data=%h pend=%h expected 1/7/00000011/00000080",
                     wb_we, wb_rd, wb_data, pend_mask);
        end
        tick();
        vectors++;
        if (wb_we !== 1'b1 || wb_rd !== 5'd7 || wb_data !== 32'h22 || pend_mask !== 32'h80) begin
            miscompares++;
            $display("FAIL same_rd_second: we=%b rd=%0d data=%h pend=%h expected 1/7/00000022/00000080",
                     wb_we, wb_rd, wb_data, pend_mask);
        end
        tick();
        vectors++;
        if (wb_we !== 1'b0 || pend_mask !== 32'h0) begin
            miscompares++; $display("FAIL same_rd_done: we=%b pend=%h expected 0/0", wb_we, pend_mask);
        end
    endtask

    task automatic test_async_reset;
        do_reset();
        req0_valid = 1'b1; req0_rd = 5'd4; req0_data = 32'h44;
        req1_valid = 1'b1; req1_rd = 5'd9; req1_data = 32'h99;
        tick();
        req0_rd = 5'd6; req0_data = 32'h66;
        req1_valid = 1'b0;
        tick();
        idle_inputs();
        vectors++;
        if (wb_we !== 1'b1 || wb_rd !== 5'd4 || pend_mask !== 32'h250) begin
            miscompares++;
            $display("FAIL areset_setup: we=%b rd=%0d pend=%h expected 1/4/00000250", wb_we, wb_rd, pend_mask);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (wb_we !== 1'b0 || wb_rd !== 5'd0 || wb_data !== 32'd0 || pend_mask !== 32'd0 ||
            req0_ready !== 1'b1 || req1_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL areset_mid: we=%b rd=%0d data=%h pend=%h rdy0=%b rdy1=%b expected 0/0/0/0/1/1",
                     wb_we, wb_rd, wb_data, pend_mask, req0_ready, req1_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            vectors++;
            if (wb_we !== 1'b0 || pend_mask !== 32'd0) begin
                miscompares++;
                $display("FAIL areset_stale k=%0d: we=%b pend=%h expected 0/0", k, wb_we, pend_mask);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_back_to_back();
        test_rd_zero();
        test_same_rd();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
